// File: rtl/vn_debiaser.sv
// Von Neumann debiaser for a ring-oscillator entropy source: 2-FF synchroniser, decimation, pair debiasing.
// Optional repetition-count health test is compiled in when VN_RCT_EN is defined.
module vn_debiaser #(
    parameter int SAMPLE_DIV = 16,
    parameter int RCT_CUTOFF = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        ro_in,
    output logic        bit_out,
    output logic        bit_valid,
    output logic [15:0] discard_cnt,
    output logic        health_fail
);

    typedef enum logic {ST_FIRST, ST_SECOND} state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic        sync1_q, sync2_q;
    logic [15:0] div_cnt_q, div_cnt_d;
    state_t      state_q, state_d;
    logic        first_bit_q, first_bit_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic [15:0] discard_cnt_q, discard_cnt_d;
    logic        strobe;
    logic        hf_block;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        strobe    = enable && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + 16'd1;
        if (!enable || strobe) begin
            div_cnt_d = 16'd0;
        end
    end

    // Pair FSM: a disabled sampler drops any half-collected pair silently.
    always_comb begin
        state_d       = state_q;
        first_bit_d   = first_bit_q;
        bit_out_d     = bit_out_q;
        bit_valid_d   = 1'b0;
        discard_cnt_d = discard_cnt_q;
        if (!enable) begin
            state_d = ST_FIRST;
        end else if (strobe) begin
            case (state_q)
                ST_FIRST: begin
                    first_bit_d = sync2_q;
                    state_d     = ST_SECOND;
                end
                ST_SECOND: begin
                    state_d = ST_FIRST;
                    if (sync2_q != first_bit_q) begin
                        bit_out_d   = first_bit_q;
                        bit_valid_d = !hf_block;
                    end else begin
                        discard_cnt_d = sat_inc16(discard_cnt_q);
                    end
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= 16'd0;
            state_q       <= ST_FIRST;
            first_bit_q   <= 1'b0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            discard_cnt_q <= 16'd0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            state_q       <= state_d;
            first_bit_q   <= first_bit_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

`ifdef VN_RCT_EN
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       last_q, last_d;
    logic       have_last_q, have_last_d;
    logic       hf_q, hf_d;

    // The failing strobe itself already suppresses any pair completing on it.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        hf_d        = hf_q;
        if (!enable) begin
            rep_cnt_d   = 8'd0;
            have_last_d = 1'b0;
        end else if (strobe) begin
            last_d      = sync2_q;
            have_last_d = 1'b1;
            if (!have_last_q || (sync2_q != last_q)) begin
                rep_cnt_d = 8'd1;
            end else if (rep_cnt_q != 8'hFF) begin
                rep_cnt_d = rep_cnt_q + 8'd1;
            end
            if (rep_cnt_d >= 8'(RCT_CUTOFF)) begin
                hf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q   <= 8'd0;
            last_q      <= 1'b0;
            have_last_q <= 1'b0;
            hf_q        <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
            hf_q        <= hf_d;
        end
    end

    assign hf_block    = hf_d;
    assign health_fail = hf_q;
`else
    logic unused_rct_cfg;
    assign unused_rct_cfg = ^RCT_CUTOFF;
    assign hf_block       = 1'b0;
    assign health_fail    = 1'b0;
`endif

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign discard_cnt = discard_cnt_q;

endmodule

// File: tb/tb_vn_debiaser.sv
// Directed bench for vn_debiaser with SAMPLE_DIV=4; expectations adapt to VN_RCT_EN.
module tb_vn_debiaser;

    localparam int SD = 4;

`ifdef VN_RCT_EN
    localparam int HF_EXP    = 1;
    localparam int RCT_PULSE = 0;
`else
    localparam int HF_EXP    = 0;
    localparam int RCT_PULSE = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        ro_in = 1'b0;
    logic        bit_out;
    logic        bit_valid;
    logic [15:0] discard_cnt;
    logic        health_fail;

    int checks = 0;
    int fails  = 0;

    int cyc = 0;
    int pulse_cnt = 0;
    int wide_cnt = 0;
    logic prev_valid = 1'b0;
    int   pulse_bit [0:63];
    int   pulse_cyc [0:63];
    int   base;

    vn_debiaser #(.SAMPLE_DIV(SD), .RCT_CUTOFF(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ro_in(ro_in),
        .bit_out(bit_out), .bit_valid(bit_valid),
        .discard_cnt(discard_cnt), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the inactive edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bit_valid === 1'b1) begin
            if (prev_valid) wide_cnt = wide_cnt + 1;
            if (pulse_cnt < 64) begin
                pulse_bit[pulse_cnt] = int'(bit_out);
                pulse_cyc[pulse_cnt] = cyc;
            end
            pulse_cnt = pulse_cnt + 1;
        end
        prev_valid = (bit_valid === 1'b1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic v);
        ro_in = v;
        repeat (SD) @(negedge clk);
    endtask

    initial begin
        #2;
        check("reset_bit_out", int'(bit_out), 0);
        check("reset_bit_valid", int'(bit_valid), 0);
        check("reset_discard", int'(discard_cnt), 0);
        check("reset_health", int'(health_fail), 0);

        @(negedge clk); rst = 1'b0;
        @(negedge clk); enable = 1'b1;

        // Unequal pairs 10 then 01
        base = pulse_cnt;
        sample(1'b1); sample(1'b0); sample(1'b0); sample(1'b1);
        #1;
        check("unequal_pulses", pulse_cnt - base, 2);
        check("unequal_bit0", pulse_bit[base], 1);
        check("unequal_bit1", pulse_bit[base+1], 0);
        check("unequal_spacing", pulse_cyc[base+1] - pulse_cyc[base], 2*SD);
        check("unequal_width", wide_cnt, 0);
        check("unequal_discard", int'(discard_cnt), 0);

        // Equal pairs 11 and 00
        base = pulse_cnt;
        sample(1'b1); sample(1'b1); sample(1'b0); sample(1'b0);
        #1;
        check("equal_pulses", pulse_cnt - base, 0);
        check("equal_discard", int'(discard_cnt), 2);
        check("equal_bit_out_hold", int'(bit_out), 0);

        // Enable abort drops the held first bit
        base = pulse_cnt;
        sample(1'b1);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("abort_valid_low", int'(bit_valid), 0);
        enable = 1'b1;
        sample(1'b0); sample(1'b1);
        #1;
        check("abort_pulses", pulse_cnt - base, 1);
        check("abort_bit", pulse_bit[base], 0);
        check("abort_discard", int'(discard_cnt), 2);

        // Leave bit_out=1, then reset asynchronously mid-cycle
        sample(1'b1); sample(1'b0);
        #1;
        check("pre_reset_bit_out", int'(bit_out), 1);
        @(posedge clk); #2;
        ro_in = 1'b1;
        rst = 1'b1;
        #1;
        check("async_bit_out", int'(bit_out), 0);
        check("async_bit_valid", int'(bit_valid), 0);
        check("async_discard", int'(discard_cnt), 0);
        check("async_health", int'(health_fail), 0);
        @(negedge clk); rst = 1'b0;

        // Constant-1 run: repetition count test
        base = pulse_cnt;
        sample(1'b1); sample(1'b1);
        #1;
        check("post_reset_quiet", pulse_cnt - base, 0);
        repeat (29) sample(1'b1);
        #1;
        check("rct_before_cutoff", int'(health_fail), 0);
        sample(1'b1);
        #1;
        check("rct_at_cutoff", int'(health_fail), HF_EXP);
        base = pulse_cnt;
        sample(1'b1); sample(1'b0);
        #1;
        check("rct_pulses", pulse_cnt - base, RCT_PULSE);
        if (RCT_PULSE == 1) check("rct_bit", pulse_bit[base], 1);
        check("rct_discard", int'(discard_cnt), 16);
        check("rct_health_sticky", int'(health_fail), HF_EXP);
        check("final_width", wide_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
